// File: rtl/if_stage.sv
// Instruction-fetch stage for the LEGv8 single-cycle core.
// Holds the PC, fetches one instruction word at a time from instruction
// memory over a ready handshake, presents it to the control unit and
// datapath, and commits the next PC once downstream acknowledges it.
module if_stage #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [10:0]       opcode,
    output logic [ADDR_W-1:0] pc,
    input  logic              instr_ack,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_offset
);

    // REQ waits for memory to return the word at pc; ISSUE holds it for downstream
    typedef enum logic {
        REQ   = 1'b0,
        ISSUE = 1'b1
    } fetchState_t;

    fetchState_t       state;
    logic [ADDR_W-1:0] pcReg;
    logic [31:0]       instrReg;
    logic [ADDR_W-1:0] pcIncrement;
    logic [ADDR_W-1:0] nextPc;

    // Branch offsets are word counts; the shift drops the top two bits, and both increments keep pc[1:0] intact
    always_comb begin
        pcIncrement = pc_src ? (branch_offset << 2) : ADDR_W'(4);
        nextPc      = pcReg + pcIncrement;
    end

    // Fetch FSM: capture the word on ready in REQ, commit the next PC on ack in ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            pcReg    <= RESET_PC;
            instrReg <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_ready) begin
                        instrReg <= imem_rdata;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ack) begin
                        pcReg <= nextPc;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

    // Handshake outputs decode only the registered state, so no input reaches them combinationally
    always_comb begin
        imem_req    = (state == REQ);
        instr_valid = (state == ISSUE);
        imem_addr   = pcReg;
        pc          = pcReg;
        instr       = instrReg;
        opcode      = instrReg[31:21];
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a scoreboard of expected (pc, word) pairs is filled
// whenever the bench hands memory data to the stage and drained whenever the
// stage presents an instruction; a next-PC model tracks every acknowledge.
module tb_if_stage;

    localparam int ADDR_W = 64;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       word;
    } expFetch_t;

    logic              clk;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [10:0]       opcode;
    logic [ADDR_W-1:0] pc;
    logic              instr_ack;
    logic              pc_src;
    logic [ADDR_W-1:0] branch_offset;

    expFetch_t         sbq[$];
    expFetch_t         exp;
    logic [ADDR_W-1:0] modelPc;
    int                testsRun;
    int                testsFailed;

    if_stage #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .instr_ack    (instr_ack),
        .pc_src       (pc_src),
        .branch_offset(branch_offset)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory answers the current request this cycle; the expected result is queued
    task automatic applyStimulus(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        sbq.push_back(expFetch_t'{pc: modelPc, word: word});
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Downstream acknowledges the current instruction; branch inputs are noise afterwards
    task automatic ackInstr(input logic src, input logic [ADDR_W-1:0] off);
        instr_ack     = 1'b1;
        pc_src        = src;
        branch_offset = off;
        modelPc       = src ? modelPc + (off << 2) : modelPc + 64'd4;
        step();
        instr_ack     = 1'b0;
        pc_src        = 1'($urandom);
        branch_offset = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        repeat (2) step();
        #3 rst = 1'b1;
        #1;
        testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        testsRun++; if (pc !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h expected 0", pc); end
        testsRun++; if (imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_req: got %b expected 1", imem_req); end
        testsRun++; if (imem_addr !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
        testsRun++; if (opcode !== 11'd0) begin testsFailed++; $display("[TB] FAIL reset_opcode: got %h expected 0", opcode); end
        imem_ready = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b0;
        modelPc = '0;
        sbq.delete();
        step();
        testsRun++; if (imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_req_after: got %b expected 1", imem_req); end
    endtask

    task automatic test_sequential();
        testsRun++; if (imem_addr !== 64'd0) begin testsFailed++; $display("[TB] FAIL seq_addr0: got %h expected 0", imem_addr); end
        applyStimulus(32'h8B020020);
        exp = sbq.pop_front();
        testsRun++; if (instr_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL seq_valid0: got %b expected 1", instr_valid); end
        testsRun++; if (pc !== exp.pc) begin testsFailed++; $display("[TB] FAIL seq_pc0: got %h expected %h", pc, exp.pc); end
        testsRun++; if (instr !== exp.word) begin testsFailed++; $display("[TB] FAIL seq_instr0: got %h expected %h", instr, exp.word); end
        testsRun++; if (opcode !== 11'h458) begin testsFailed++; $display("[TB] FAIL seq_opcode0: got %h expected 458", opcode); end
        ackInstr(1'b0, 64'd0);
        testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL seq_gap: got %b expected 0", instr_valid); end
        testsRun++; if (imem_addr !== modelPc) begin testsFailed++; $display("[TB] FAIL seq_addr1: got %h expected %h", imem_addr, modelPc); end
        applyStimulus(32'h8B030040);
        exp = sbq.pop_front();
        testsRun++; if (instr_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL seq_valid1: got %b expected 1", instr_valid); end
        testsRun++; if (pc !== exp.pc) begin testsFailed++; $display("[TB] FAIL seq_pc1: got %h expected %h", pc, exp.pc); end
        testsRun++; if (opcode !== exp.word[31:21]) begin testsFailed++; $display("[TB] FAIL seq_opcode1: got %h expected %h", opcode, exp.word[31:21]); end
        ackInstr(1'b0, 64'd0);
        testsRun++; if (imem_addr !== 64'd8) begin testsFailed++; $display("[TB] FAIL seq_addr2: got %h expected 8", imem_addr); end
    endtask

    task automatic test_branch();
        applyStimulus(32'hB4000060);
        exp = sbq.pop_front();
        ackInstr(1'b1, 64'd6);
        testsRun++; if (imem_addr !== 64'h20) begin testsFailed++; $display("[TB] FAIL br_to20: got %h expected 20", imem_addr); end
        applyStimulus(32'h17FFFFFD);
        exp = sbq.pop_front();
        testsRun++; if (pc !== exp.pc) begin testsFailed++; $display("[TB] FAIL br_pc20: got %h expected %h", pc, exp.pc); end
        ackInstr(1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        testsRun++; if (imem_addr !== 64'h14) begin testsFailed++; $display("[TB] FAIL br_back: got %h expected 14", imem_addr); end
        applyStimulus(32'h14000002);
        exp = sbq.pop_front();
        ackInstr(1'b1, 64'd2);
        testsRun++; if (imem_addr !== 64'h1C) begin testsFailed++; $display("[TB] FAIL br_fwd: got %h expected 1c", imem_addr); end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            instr_ack  = 1'($urandom);
            step();
            testsRun++; if (imem_req !== 1'b1 || imem_addr !== modelPc || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL wait_hold%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", i, imem_req, imem_addr, instr_valid, modelPc); end
        end
        instr_ack = 1'b0;
        applyStimulus(32'hF8400020);
        exp = sbq.pop_front();
        testsRun++; if (instr !== exp.word || pc !== exp.pc || instr_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL wait_capture: got instr=%h pc=%h valid=%b expected instr=%h pc=%h valid=1", instr, pc, instr_valid, exp.word, exp.pc); end
        ackInstr(1'b0, 64'd0);
    endtask

    task automatic test_stall_reset();
        applyStimulus(32'hCB010000);
        exp = sbq.pop_front();
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            step();
            testsRun++; if (instr !== exp.word || pc !== exp.pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_hold%0d: got instr=%h pc=%h req=%b expected instr=%h pc=%h req=0", i, instr, pc, imem_req, exp.word, exp.pc); end
        end
        imem_ready = 1'b0;
        ackInstr(1'b0, 64'd0);
        step();
        #3 rst = 1'b1;
        #1;
        testsRun++; if (pc !== 64'd0 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_rst: got pc=%h valid=%b expected pc=0 valid=0", pc, instr_valid); end
        step();
        rst = 1'b0;
        modelPc = '0;
        sbq.delete();
        applyStimulus(32'h91000421);
        exp = sbq.pop_front();
        testsRun++; if (pc !== 64'd0 || instr !== exp.word) begin testsFailed++; $display("[TB] FAIL stall_refetch: got pc=%h instr=%h expected pc=0 instr=%h", pc, instr, exp.word); end
        ackInstr(1'b0, 64'd0);
    endtask

    task automatic test_wrap();
        applyStimulus(32'h14000000);
        exp = sbq.pop_front();
        ackInstr(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        testsRun++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin testsFailed++; $display("[TB] FAIL wrap_top: got %h expected fffffffffffffffc", imem_addr); end
        applyStimulus(32'hD503201F);
        exp = sbq.pop_front();
        testsRun++; if (pc !== exp.pc) begin testsFailed++; $display("[TB] FAIL wrap_toppc: got %h expected %h", pc, exp.pc); end
        ackInstr(1'b0, 64'd0);
        testsRun++; if (imem_addr !== 64'd0) begin testsFailed++; $display("[TB] FAIL wrap_seq: got %h expected 0", imem_addr); end
        applyStimulus(32'h17FFFFFF);
        exp = sbq.pop_front();
        ackInstr(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(32'h14000001);
        exp = sbq.pop_front();
        testsRun++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin testsFailed++; $display("[TB] FAIL wrap_top2: got %h expected fffffffffffffffc", pc); end
        ackInstr(1'b1, 64'd1);
        testsRun++; if (imem_addr !== 64'd0) begin testsFailed++; $display("[TB] FAIL wrap_br: got %h expected 0", imem_addr); end
    endtask

    // Run every scenario in order and report one summary line
    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        modelPc       = '0;
        rst           = 1'b0;
        imem_ready    = 1'b0;
        imem_rdata    = '0;
        instr_ack     = 1'b0;
        pc_src        = 1'b0;
        branch_offset = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_wait_states();
        test_stall_reset();
        test_wrap();
        testsRun++; if (sbq.size() !== 0) begin testsFailed++; $display("[TB] FAIL sb_drain: got %0d entries expected 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
